// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: word width, bubble encoding, PC step
// and the fetch-state encoding used when IF_HALT_ON_NULL_EN is defined.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package instruction_fetch_pkg;
  localparam int WORD_WIDTH = `WORD_WIDTH;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0;
  localparam logic [WORD_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
import instruction_fetch_pkg::*;

module if_id_reg (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] d_pc,
  input  logic [WORD_WIDTH-1:0] d_instr,
  input  logic                  d_valid,
  output logic [WORD_WIDTH-1:0] q_pc,
  output logic [WORD_WIDTH-1:0] q_instr,
  output logic                  q_valid
);

  logic [WORD_WIDTH-1:0] pc_reg;
  logic [WORD_WIDTH-1:0] instr_reg;
  logic                  valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (flush) begin
      pc_reg    <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (!hold) begin
      pc_reg    <= d_pc;
      instr_reg <= d_instr;
      valid_reg <= d_valid;
    end
  end

  assign q_pc    = pc_reg;
  assign q_instr = instr_reg;
  assign q_valid = valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection and IF/ID capture.
// Define IF_HALT_ON_NULL_EN to halt fetch when an all-zero word is read.
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [`WORD_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [`WORD_WIDTH-1:0] branch_addr,
  output logic [`WORD_WIDTH-1:0] mem_addr,
  input  logic [`WORD_WIDTH-1:0] mem_instr,
  output logic [`WORD_WIDTH-1:0] if_pc,
  output logic [`WORD_WIDTH-1:0] if_instr,
  output logic                   if_valid,
  output logic                   halted
);

  // PC kept as a word index; the byte PC always has zero low bits.
  logic [WORD_WIDTH-3:0] pc_word_reg;
  logic [WORD_WIDTH-3:0] pc_word_next;
  logic [WORD_WIDTH-1:0] pc_byte;
  logic [WORD_WIDTH-1:0] pc_plus4;
  logic                  fetch_normal;
  logic                  unused_bits;

  assign pc_byte  = {pc_word_reg, 2'b00};
  assign pc_plus4 = pc_byte + PC_STEP;
  assign mem_addr = {2'b00, pc_word_reg};

  assign unused_bits = &{1'b0, branch_addr[1:0], pc_plus4[1:0]};

`ifdef IF_HALT_ON_NULL_EN
  fetch_state_e state_reg;
  fetch_state_e state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    fetch_normal = 1'b0;
    if (state_reg == RUN) begin
      fetch_normal = (mem_instr != NOP_INSTR);
      if (!branch_taken && !freeze && !fetch_normal) state_next = HALTED;
    end
    if (branch_taken) state_next = RUN;
  end

  assign halted = (state_reg == HALTED);
`else
  assign fetch_normal = 1'b1;
  assign halted       = 1'b0;
`endif

  always_comb begin
    pc_word_next = pc_word_reg;
    if (branch_taken)      pc_word_next = branch_addr[WORD_WIDTH-1:2];
    else if (freeze)       pc_word_next = pc_word_reg;
    else if (fetch_normal) pc_word_next = pc_plus4[WORD_WIDTH-1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_word_reg <= RESET_PC[WORD_WIDTH-1:2];
    else     pc_word_reg <= pc_word_next;
  end

  // A halted fetch loads bubbles into IF/ID instead of the fetched word.
  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (freeze),
    .flush   (branch_taken),
    .d_pc    (fetch_normal ? pc_plus4 : '0),
    .d_instr (fetch_normal ? mem_instr : NOP_INSTR),
    .d_valid (fetch_normal),
    .q_pc    (if_pc),
    .q_instr (if_instr),
    .q_valid (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected IF/ID state,
// a negedge monitor pops and compares.
module tb_instruction_fetch;

`ifdef IF_HALT_ON_NULL_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;

  int total = 0;
  int bad = 0;
  int txn = 0;

  logic [31:0] rom [0:63];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        hlt;
  } exp_t;
  exp_t exp_q [$];

  // Reference state, in byte-address terms.
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_if_valid;
  logic        m_halted;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_addr     (mem_addr),
    .mem_instr    (mem_instr),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  always_comb mem_instr = rom[mem_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0; m_halted = 1'b0;
  endtask

  // Called right after a negedge: drive inputs, advance model, push expectation.
  task automatic step(input logic f, input logic b, input logic [31:0] a);
    logic [31:0] word;
    exp_t e;
    freeze = f; branch_taken = b; branch_addr = a;
    word = rom[m_pc[7:2]];
    if (b) begin
      m_pc = a & 32'hFFFF_FFFC;
      m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0; m_halted = 1'b0;
    end else if (f) begin
      // everything holds
    end else if (HALT_EN && (m_halted || word == 32'h0)) begin
      m_halted = 1'b1;
      m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
      m_if_pc = m_pc; m_if_instr = word; m_if_valid = 1'b1;
    end
    @(posedge clk);
    e.addr = m_pc >> 2; e.pc4 = m_if_pc; e.instr = m_if_instr;
    e.valid = m_if_valid; e.hlt = m_halted;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    int bad_before;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        bad_before = bad;
        chk("mem_addr", mem_addr, e.addr);
        chk("if_pc", if_pc, e.pc4);
        chk("if_instr", if_instr, e.instr);
        chk("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
        chk("halted", {31'b0, halted}, {31'b0, e.hlt});
        txn++;
        if (bad == bad_before)
          $display("txn %0d addr=%h if_pc=%h if_instr=%h v=%0b h=%0b ok",
                   txn, mem_addr, if_pc, if_instr, if_valid, halted);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      while (w == 32'h0) w = $urandom;
      rom[i] = w;
    end
    rom[0]  = 32'hE3A00014;
    rom[27] = 32'h0;
    model_reset();

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Free run, freeze at pc=8, release.
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    // Branch with simultaneous freeze, then a normal edge.
    step(1, 1, 32'h0000_003E);
    step(0, 0, 0);
    // Consecutive branches, then wrap at the top of the address space.
    step(0, 1, 32'h0000_0010);
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    step(0, 0, 0);

    if (HALT_EN) begin
      step(0, 1, 32'h0000_0060);
      for (int i = 0; i < 9; i++) step(0, 0, 0);
      step(1, 0, 0);
      step(0, 1, 32'h0000_0000);
      step(0, 0, 0); step(0, 0, 0);
    end else begin
      // Null word fetched as an ordinary instruction.
      step(0, 1, 32'h0000_006C);
      step(0, 0, 0);
    end

    for (int i = 0; i < 300; i++) begin
      logic f, b;
      f = ($urandom_range(3) == 0);
      b = ($urandom_range(7) == 0);
      if (b && $urandom_range(3) == 0) step(f, b, 32'h0000_0060 | $urandom_range(3));
      else step(f, b, $urandom);
    end

    // Asynchronous reset mid-cycle while frozen.
    step(0, 1, 32'h0000_0080);
    step(0, 0, 0);
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async");
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("held");
    rst = 1'b0;
    model_reset();
    step(0, 0, 0); step(0, 0, 0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
